// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash slave: opcodes, FSM states and address width.
`timescale 1ns/1ps
package spi_flash_pkg;

  localparam int ADDR_BITS = 24;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_WRDI      = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DOUT,
    ST_DIN,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle rise/fall pulses.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LVL    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {SYNC_STAGES{IDLE_LVL}};
      prev  <= IDLE_LVL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_flash_slave.sv
// Mode-0 SPI flash slave with small byte-wide storage, READ/FAST_READ/PP/RDSR/WREN/WRDI.
`timescale 1ns/1ps
module spi_flash_slave
  import spi_flash_pkg::*;
#(
  parameter int MEM_BYTES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic wel
);

  localparam int           AW            = $clog2(MEM_BYTES);
  localparam logic [4:0]   BYTE_LAST     = 5'd7;
  localparam logic [4:0]   ADDR_LAST     = 5'(ADDR_BITS - 1);
  localparam logic [7:0]   FLUSH_N       = 8'(SYNC_STAGES + 1);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sck (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_t          state;
  logic [4:0]      bit_cnt;
  logic [6:0]      sh;
  logic [7:0]      op;
  logic [AW-1:0]   addr;
  logic [7:0]      tx;
  logic [7:0]      mem [MEM_BYTES];
  logic [7:0]      flush;
  logic            armed;

  logic [7:0]      byte_nx;
  logic [AW-1:0]   addr_inc;
  logic            sck_r, sck_f;

  function automatic logic [7:0] status_byte(input logic w);
    return {6'b0, w, 1'b0};
  endfunction

  assign byte_nx  = {sh, mosi_lvl};
  assign addr_inc = addr + 1'b1;
  assign sck_r    = sck_rise & ~cs_lvl;
  assign sck_f    = sck_fall & ~cs_lvl;

  // After reset the CS_N synchroniser must flush and show the pin high before a fall is trusted,
  // so a master still holding CS_N low cannot resume an aborted transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      op      <= '0;
      addr    <= '0;
      tx      <= '0;
      miso    <= 1'b0;
      wel     <= 1'b0;
      flush   <= '0;
      armed   <= 1'b0;
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'hFF;
    end else begin
      if (flush != FLUSH_N) flush <= flush + 8'd1;
      else if (cs_lvl)      armed <= 1'b1;

      if (cs_rise) begin
        state   <= ST_IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
        if (state == ST_DIN)                           wel <= 1'b0;
        else if (state == ST_IGNORE && op == OP_WREN)  wel <= 1'b1;
        else if (state == ST_IGNORE && op == OP_WRDI)  wel <= 1'b0;
      end else if (state == ST_IDLE) begin
        if (cs_fall && armed) begin
          state   <= ST_CMD;
          bit_cnt <= '0;
        end
      end else if (sck_r) begin
        sh      <= byte_nx[6:0];
        bit_cnt <= bit_cnt + 5'd1;
        case (state)
          ST_CMD: if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            op      <= byte_nx;
            case (byte_nx)
              OP_READ, OP_FAST_READ, OP_PP: state <= ST_ADDR;
              OP_RDSR: begin
                state <= ST_DOUT;
                tx    <= status_byte(wel);
              end
              default: state <= ST_IGNORE;
            endcase
          end
          ST_ADDR: if (bit_cnt == ADDR_LAST) begin
            bit_cnt <= '0;
            addr    <= byte_nx[AW-1:0];
            if (op == OP_READ) begin
              state <= ST_DOUT;
              tx    <= mem[byte_nx[AW-1:0]];
            end else if (op == OP_FAST_READ) begin
              state <= ST_DUMMY;
            end else if (wel) begin
              state <= ST_DIN;
            end else begin
              state <= ST_IGNORE;
            end
          end
          ST_DUMMY: if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            state   <= ST_DOUT;
            tx      <= mem[addr];
          end
          ST_DOUT: if (bit_cnt == BYTE_LAST) begin
            bit_cnt <= '0;
            if (op == OP_RDSR) begin
              tx <= status_byte(wel);
            end else begin
              addr <= addr_inc;
              tx   <= mem[addr_inc];
            end
          end
          ST_DIN: if (bit_cnt == BYTE_LAST) begin
            bit_cnt   <= '0;
            mem[addr] <= mem[addr] & byte_nx;
            addr      <= addr_inc;
          end
          default: ;
        endcase
      end else if (sck_f && state == ST_DOUT) begin
        miso <= tx[7];
        tx   <= {tx[6:0], 1'b0};
      end
    end
  end

endmodule

// File: doc/spi_flash_slave.md
SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

Interface
REQ-001 Parameter MEM_BYTES, default 16, SHALL set the storage size in bytes; it is a power of two, 2..256.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the synchroniser depth on SCK, CS_N and MOSI.
REQ-003 CLK  input  1  SHALL be the single system clock; all state is clocked on its rising edge.
REQ-004 RESET  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 SCK  input  1  SHALL be the SPI serial clock from the master, asynchronous to CLK, at most CLK/4.
REQ-006 CS_N  input  1  SHALL be the active-low chip select from the master.
REQ-007 MOSI  input  1  SHALL be the serial data from the master, MSB first.
REQ-008 MISO  output  1  SHALL be the serial data to the master, MSB first; driven 0 when not shifting.
REQ-009 WEL  output  1  SHALL reflect the internal write-enable latch.

Function
REQ-010 Synchronisation: SCK, CS_N and MOSI SHALL pass through SYNC_STAGES flops; SCK rise/fall and CS_N fall/rise SHALL be detected as single-CLK pulses.
REQ-011 Mode: SPI mode 0; MOSI SHALL be sampled on the synchronised SCK rise; MISO SHALL update on the synchronised SCK fall, within 3 CLK cycles of the pin edge.
REQ-012 FSM states: IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE.
REQ-013 IDLE -> CMD on CS_N fall; the bit counter SHALL clear.
REQ-014 CMD: after 8 bits, decode the opcode.
  - 0x03 READ -> ADDR
  - 0x0B FAST_READ -> ADDR, then DUMMY
  - 0x02 PAGE_PROGRAM -> ADDR
  - 0x05 READ_STATUS -> DOUT with status byte {6'b0, WEL, 1'b0}
  - 0x06 WREN -> IGNORE; set WEL at CS_N rise
  - 0x04 WRDI -> IGNORE; clear WEL at CS_N rise
  - any other opcode -> IGNORE
REQ-015 ADDR SHALL shift in 24 bits; only addr[log2(MEM_BYTES)-1:0] SHALL be used.
REQ-016 After ADDR: READ -> DOUT; FAST_READ -> DUMMY (8 bits ignored) -> DOUT; PAGE_PROGRAM -> DIN if WEL=1, else IGNORE.
REQ-017 DOUT: the byte at the current address SHALL be loaded so its MSB appears on the first SCK fall after the last address/dummy bit; the address SHALL increment after each 8 bits.
REQ-018 READ_STATUS SHALL repeat the status byte for as long as CS_N stays low.
REQ-019 DIN: each completed byte SHALL be written as mem[addr] <= mem[addr] & byte (flash semantics, 1->0 only); the address SHALL then increment.
REQ-020 The address SHALL wrap from MEM_BYTES-1 to 0 in both DOUT and DIN.
REQ-021 CS_N rise in any state SHALL return the FSM to IDLE next cycle; a partial byte SHALL be discarded, with no memory write.
REQ-022 WEL SHALL clear at the CS_N rise that ends any PAGE_PROGRAM that reached DIN, even if zero bytes were written.
REQ-023 When an SCK edge and a CS_N rise are detected in the same cycle, the CS_N rise SHALL win.
REQ-024 SCK edges while CS_N is high SHALL be ignored.
REQ-025 MISO SHALL be 0 in IDLE, CMD, ADDR, DUMMY, DIN and IGNORE.

Reset
REQ-026 RESET low SHALL asynchronously set: FSM IDLE, MISO 0, WEL 0, counters 0, synchronisers to idle levels (SCK 0, CS_N 1, MOSI 0).
REQ-027 Storage SHALL initialise to 0xFF on reset.
REQ-028 Reset mid-transaction SHALL abort it; after RESET goes high, the FSM SHALL wait for a fresh CS_N fall.

Structure
REQ-029 A shared package spi_flash_pkg SHALL hold the opcode constants (0x03, 0x0B, 0x02, 0x05, 0x06, 0x04), the state enum, and ADDR_BITS=24.
REQ-030 Synchroniser plus edge detect SHALL be one sub-module, spi_sync_edge, instantiated once per input.

Verification
REQ-031 Reset, then READ 0x03 addr 0x000000, 16 bytes -> MISO returns 0xFF x16; WEL=0.
REQ-032 WREN, then PP 0x02 addr 0x000004 with data 0xAA,0x55, then READ addr 0x000004, 2 bytes -> 0xAA,0x55; WEL=1 after WREN, 0 after PP.
REQ-033 PP without WREN at addr 0x000000 with data 0x00, then READ -> 0xFF (write blocked).
REQ-034 FAST_READ 0x0B addr 0x00000F, dummy 0x00, 3 bytes -> mem[15], mem[0], mem[1] (wrap-around).
REQ-035 WREN, then RDSR 0x05 -> 0x02; PP with CS_N raised after 4 data bits -> memory unchanged, WEL=0.
REQ-036 Assert RESET during DOUT -> MISO 0 immediately; the next READ works normally, and memory is restored to 0xFF.
